// File: rtl/fp16_dot_pkg.sv
// fp16_dot_pkg
//   Shared types and constants for the fp16 dot-product sequencer.
//   - state_t           : sequencer FSM encoding
//   - FP16_* constants  : fp16 bit patterns and exponent field bounds
//   - fp16_is_special() : true for Inf/NaN (all-ones exponent)
package fp16_dot_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    FEED  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [15:0] FP16_ZERO    = 16'h0000;
  localparam logic [15:0] FP16_QNAN    = 16'h7E00;
  localparam int          FP16_EXP_MSB = 14;
  localparam int          FP16_EXP_LSB = 10;

  function automatic logic fp16_is_special(input logic [15:0] x);
    return &x[FP16_EXP_MSB:FP16_EXP_LSB];
  endfunction

endpackage

// File: rtl/fp16_dot_seq.sv
// fp16_dot_seq
//   Dot-product sequencer sitting in front of an fp16 multiply-accumulate unit.
//   A job of len operand pairs is run as: clear the MAC, stream the pairs into
//   it, wait for the MAC pipeline to drain, then hold the captured accumulator
//   on a valid/ready output until it is taken.
//
//   Handshakes: a transfer happens on a rising CLK edge where valid and ready
//   are both high. in_ready is high exactly while in FEED; out_valid is high
//   exactly while in DONE and out_data is stable for as long as it is high.
//
//   Ports
//     CLK, RESETn          clock (rising edge), async active-low reset
//     start, len           begin a job of len pairs (accepted only when idle)
//     in_valid/in_ready    operand pair stream, in_a/in_b fp16 operands
//     mac_a, mac_b         registered operands to the MAC (0 when not feeding)
//     mac_clr_n            registered active-low clear to the MAC
//     mac_acc              MAC accumulator value
//     out_valid/out_ready  result handshake, out_data fp16 result
//     busy                 high whenever not idle
//     nan_flag             (only with FP16_DOT_NANCHK_EN) an Inf/NaN operand
//                          was seen in this job; presented with out_valid
//
//   Build option: define FP16_DOT_NANCHK_EN to add Inf/NaN operand detection.
//   When any accepted operand has an all-ones exponent, the result is forced
//   to the canonical quiet NaN and nan_flag is raised alongside out_valid.
module fp16_dot_seq
  import fp16_dot_pkg::*;
#(
  parameter int LEN_W   = 8,
  parameter int MAC_LAT = 4,
  parameter int CLR_CYC = 2
) (
  input  logic             CLK,
  input  logic             RESETn,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_a,
  input  logic [15:0]      in_b,
  output logic [15:0]      mac_a,
  output logic [15:0]      mac_b,
  output logic             mac_clr_n,
  input  logic [15:0]      mac_acc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_data,
  output logic             busy
`ifdef FP16_DOT_NANCHK_EN
  ,
  output logic             nan_flag
`endif
);

  // One down-counter serves both the clear hold and the drain wait, so it
  // is sized for the longer of the two.
  localparam int CNT_MAX = (MAC_LAT > CLR_CYC) ? MAC_LAT : CLR_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_CLR   = CNT_W'(CLR_CYC);
  localparam logic [CNT_W-1:0] CNT_DRAIN = CNT_W'(MAC_LAT);
  localparam logic [LEN_W-1:0] REM_ONE   = LEN_W'(1);
  localparam logic [LEN_W-1:0] REM_ZERO  = '0;

  state_t           state;
  state_t           state_nxt;
  logic [LEN_W-1:0] rem;
  logic [CNT_W-1:0] cnt;
  logic             in_fire;
  logic             start_ok;
  logic             last_beat;
  logic             cnt_last;

  assign in_ready  = (state == FEED);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  assign in_fire   = in_valid & in_ready;
  assign start_ok  = start & (state == IDLE);
  assign last_beat = in_fire & (rem == REM_ONE);
  assign cnt_last  = (cnt == CNT_ONE);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          // A zero-length product is exactly +0, so skip the MAC entirely.
          state_nxt = (len == REM_ZERO) ? DONE : CLEAR;
        end
      end
      CLEAR: begin
        if (cnt_last) state_nxt = FEED;
      end
      FEED: begin
        if (last_beat) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (cnt_last) state_nxt = DONE;
      end
      DONE: begin
        // start is deliberately not looked at here: a start coinciding with
        // the result handshake is dropped, not carried into IDLE.
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Job bookkeeping: remaining pairs and the clear/drain counter.
  // rem is loaded with a non-zero len and FEED leaves on rem==1, so it never
  // decrements through zero.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      rem <= '0;
      cnt <= '0;
    end else begin
      if (start_ok && (len != REM_ZERO)) begin
        rem <= len;
      end else if (in_fire) begin
        rem <= rem - REM_ONE;
      end

      if (start_ok) begin
        cnt <= CNT_CLR;
      end else if (last_beat) begin
        cnt <= CNT_DRAIN;
      end else if ((state == CLEAR) || (state == DRAIN)) begin
        cnt <= cnt - CNT_ONE;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // MAC interface. The MAC accumulates every clock, so anything other than an
  // accepted pair is presented as +0 * +0 and leaves the sum untouched.
  // mac_clr_n is registered from the next state so it is low for exactly the
  // cycles spent in CLEAR.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      mac_a     <= FP16_ZERO;
      mac_b     <= FP16_ZERO;
      mac_clr_n <= 1'b1;
    end else begin
      mac_a     <= in_fire ? in_a : FP16_ZERO;
      mac_b     <= in_fire ? in_b : FP16_ZERO;
      mac_clr_n <= (state_nxt != CLEAR);
    end
  end

`ifdef FP16_DOT_NANCHK_EN
  // ---------------------------------------------------------------------------
  // Sticky Inf/NaN detector. Cleared whenever a job is accepted (which covers
  // entry to CLEAR and the zero-length shortcut), set by any accepted operand
  // with an all-ones exponent.
  // ---------------------------------------------------------------------------
  logic nan_sticky;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      nan_sticky <= 1'b0;
    end else if (start_ok) begin
      nan_sticky <= 1'b0;
    end else if (in_fire && (fp16_is_special(in_a) || fp16_is_special(in_b))) begin
      nan_sticky <= 1'b1;
    end
  end

  assign nan_flag = nan_sticky & out_valid;
`endif

  // ---------------------------------------------------------------------------
  // Result capture. Only written on the zero-length shortcut and on the last
  // drain cycle, so it holds steady throughout DONE.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      out_data <= FP16_ZERO;
    end else if (start_ok && (len == REM_ZERO)) begin
      out_data <= FP16_ZERO;
    end else if ((state == DRAIN) && cnt_last) begin
`ifdef FP16_DOT_NANCHK_EN
      out_data <= nan_sticky ? FP16_QNAN : mac_acc;
`else
      out_data <= mac_acc;
`endif
    end
  end

endmodule

// File: tb/tb_fp16_dot_seq.sv
// tb_fp16_dot_seq
//   Bench for fp16_dot_seq. A behavioural fp16 MAC sits on the mac_* port
//   (multiply stage, one extra pipeline stage, accumulator register, synchronous
//   clear), so results are produced by real arithmetic and compared against
//   hand-computed fp16 constants. Expected results are queued when a job is
//   started; a monitor pops and compares on every result handshake.
module tb_fp16_dot_seq;

  localparam int LEN_W   = 8;
  localparam int MAC_LAT = 4;
  localparam int CLR_CYC = 2;

  logic             CLK;
  logic             RESETn;
  logic             start;
  logic [LEN_W-1:0] len;
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_a;
  logic [15:0]      in_b;
  logic [15:0]      mac_a;
  logic [15:0]      mac_b;
  logic             mac_clr_n;
  logic [15:0]      mac_acc;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      out_data;
  logic             busy;
`ifdef FP16_DOT_NANCHK_EN
  logic             nan_flag;
`endif

  fp16_dot_seq #(
    .LEN_W  (LEN_W),
    .MAC_LAT(MAC_LAT),
    .CLR_CYC(CLR_CYC)
  ) dut (
    .CLK      (CLK),
    .RESETn   (RESETn),
    .start    (start),
    .len      (len),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .mac_a    (mac_a),
    .mac_b    (mac_b),
    .mac_clr_n(mac_clr_n),
    .mac_acc  (mac_acc),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .busy     (busy)
`ifdef FP16_DOT_NANCHK_EN
    ,
    .nan_flag (nan_flag)
`endif
  );

  // ---------------------------------------------------------------------------
  // Clock / cycle counter / watchdog
  // ---------------------------------------------------------------------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc = cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Behavioural fp16 MAC
  // ---------------------------------------------------------------------------
  function automatic real pow2(input int n);
    real r;
    r = 1.0;
    if (n >= 0) begin
      for (int i = 0; i < n; i++) r = r * 2.0;
    end else begin
      for (int i = 0; i < -n; i++) r = r / 2.0;
    end
    return r;
  endfunction

  function automatic real fp16_to_real(input logic [15:0] x);
    int  e;
    real m;
    real r;
    e = int'(x[14:10]);
    m = real'(x[9:0]);
    if (e == 31)     r = 1.0e9;
    else if (e == 0) r = m * pow2(-24);
    else             r = (1.0 + m / 1024.0) * pow2(e - 15);
    return x[15] ? -r : r;
  endfunction

  function automatic logic [15:0] real_to_fp16(input real v);
    real        x;
    int         e;
    logic       s;
    logic [9:0] m;
    if (v == 0.0) return 16'h0000;
    s = (v < 0.0);
    x = s ? -v : v;
    e = 15;
    while (x >= 2.0 && e < 60) begin x = x / 2.0; e++; end
    while (x < 1.0 && e > -30) begin x = x * 2.0; e--; end
    if (e >= 31) return {s, 15'h7C00};
    if (e <= 0)  return {s, 15'h0000};
    m = 10'($rtoi((x - 1.0) * 1024.0));
    return {s, 5'(e), m};
  endfunction

  real p0_r = 0.0;
  real p1_r = 0.0;
  real acc_r = 0.0;

  always @(posedge CLK) begin
    if (!mac_clr_n) begin
      p0_r  <= 0.0;
      p1_r  <= 0.0;
      acc_r <= 0.0;
    end else begin
      p0_r  <= fp16_to_real(mac_a) * fp16_to_real(mac_b);
      p1_r  <= p0_r;
      acc_r <= acc_r + p1_r;
    end
  end

  always_comb mac_acc = real_to_fp16(acc_r);

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_q[$];
  logic        nan_q[$];

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [15:0] d, input logic nan);
    exp_q.push_back(d);
    nan_q.push_back(nan);
  endtask

  // Monitor: every result handshake consumes one expected entry.
  always @(negedge CLK) begin
    if (RESETn && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result actual=%h expected=none (t=%0t)", out_data, $time);
      end else begin
        logic [15:0] e_d;
        logic        e_n;
        e_d = exp_q.pop_front();
        e_n = nan_q.pop_front();
        check16("result", out_data, e_d);
`ifdef FP16_DOT_NANCHK_EN
        check16("nan_flag", {15'h0, nan_flag}, {15'h0, e_n});
`else
        if (e_n) $display("note: nan expectation ignored without nan check build");
`endif
      end
    end
  end

  logic clr_low_seen = 1'b0;
  always @(negedge CLK) if (!mac_clr_n) clr_low_seen = 1'b1;

  // ---------------------------------------------------------------------------
  // Driver tasks (all driving happens 1 time unit after a rising edge)
  // ---------------------------------------------------------------------------
  int start_cyc = 0;

  task automatic pulse_start(input int l);
    @(posedge CLK); #1;
    start     = 1'b1;
    len       = LEN_W'(l);
    start_cyc = cyc;
    @(posedge CLK); #1;
    start     = 1'b0;
  endtask

  task automatic send_pair(input logic [15:0] a, input logic [15:0] b, input bit gap_after);
    bit got;
    got      = 1'b0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    for (int k = 0; k < 50; k++) begin
      @(negedge CLK);
      if (in_ready) begin got = 1'b1; break; end
    end
    @(posedge CLK); #1;
    in_valid = 1'b0;
    in_a     = 16'h0000;
    in_b     = 16'h0000;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout actual=0 expected=1 (t=%0t)", $time);
    end else begin
      check16("mac_a_pass", mac_a, a);
      check16("mac_b_pass", mac_b, b);
    end
    if (gap_after) begin
      @(posedge CLK); #1;
      check16("gap_mac_a", mac_a, 16'h0000);
      check16("gap_mac_b", mac_b, 16'h0000);
    end
  endtask

  task automatic wait_valid(output int lat);
    bit got;
    got = 1'b0;
    lat = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge CLK);
      if (out_valid) begin got = 1'b1; break; end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL out_valid_timeout actual=0 expected=1 (t=%0t)", $time);
    end else begin
      lat = cyc - start_cyc;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check16({tag, "_in_ready"},  {15'h0, in_ready},  16'h0000);
    check16({tag, "_mac_a"},     mac_a,              16'h0000);
    check16({tag, "_mac_b"},     mac_b,              16'h0000);
    check16({tag, "_mac_clr_n"}, {15'h0, mac_clr_n}, 16'h0001);
    check16({tag, "_out_valid"}, {15'h0, out_valid}, 16'h0000);
    check16({tag, "_out_data"},  out_data,           16'h0000);
    check16({tag, "_busy"},      {15'h0, busy},      16'h0000);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  logic [15:0] t1_a [3] = '{16'h3C00, 16'h4000, 16'h4200};
  logic [15:0] t1_b [3] = '{16'h4000, 16'h4000, 16'h4000};

  initial begin
    int lat;
    RESETn    = 1'b0;
    start     = 1'b0;
    len       = '0;
    in_valid  = 1'b0;
    in_a      = 16'h0000;
    in_b      = 16'h0000;
    out_ready = 1'b1;

    #12;
    check_reset_outputs("reset");
    @(posedge CLK); #1;
    RESETn = 1'b1;
    @(posedge CLK); #1;

    // 1: back-to-back 1*2 + 2*2 + 3*2 = 12.0, latency 1+CLR_CYC+N+MAC_LAT
    push_exp(16'h4A00, 1'b0);
    pulse_start(3);
    for (int i = 0; i < 3; i++) send_pair(t1_a[i], t1_b[i], 1'b0);
    wait_valid(lat);
    check_int("latency_len3", lat, 1 + CLR_CYC + 3 + MAC_LAT);
    @(posedge CLK); #1;
    check16("idle_after_t1", {15'h0, busy}, 16'h0000);

    // 2: four 1*1 with a bubble after each of the first three pairs
    push_exp(16'h4400, 1'b0);
    pulse_start(4);
    for (int i = 0; i < 4; i++) send_pair(16'h3C00, 16'h3C00, (i < 3));
    wait_valid(lat);
    @(posedge CLK); #1;

    // 3: zero length goes straight to DONE without clearing the MAC
    clr_low_seen = 1'b0;
    push_exp(16'h0000, 1'b0);
    pulse_start(0);
    check16("len0_out_valid", {15'h0, out_valid}, 16'h0001);
    wait_valid(lat);
    check_int("latency_len0", lat, 1);
    @(posedge CLK); #1;
    check16("len0_no_clear", {15'h0, clr_low_seen}, 16'h0000);

    // 4: result held under back-pressure, start pulses ignored meanwhile
    out_ready = 1'b0;
    push_exp(16'h4500, 1'b0);
    pulse_start(2);
    send_pair(16'h4000, 16'h3C00, 1'b0);
    send_pair(16'h4200, 16'h3C00, 1'b0);
    wait_valid(lat);
    for (int i = 0; i < 5; i++) begin
      check16("hold_out_valid", {15'h0, out_valid}, 16'h0001);
      check16("hold_out_data", out_data, 16'h4500);
      check16("hold_busy", {15'h0, busy}, 16'h0001);
      @(posedge CLK); #1;
      start = (i % 2 == 0);
      len   = LEN_W'(3);
      @(negedge CLK);
    end
    @(posedge CLK); #1;
    start     = 1'b1;
    out_ready = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    check16("post_hs_out_valid", {15'h0, out_valid}, 16'h0000);
    check16("post_hs_busy", {15'h0, busy}, 16'h0000);
    @(posedge CLK); #1;
    check16("start_not_queued", {15'h0, busy}, 16'h0000);

    // 5: reset in the middle of FEED, then a fresh len=1 job
    pulse_start(5);
    send_pair(16'h4000, 16'h4000, 1'b0);
    send_pair(16'h4000, 16'h4000, 1'b0);
    RESETn = 1'b0;
    #2;
    check_reset_outputs("abort");
    @(posedge CLK); #1;
    RESETn = 1'b1;
    push_exp(16'h3C00, 1'b0);
    pulse_start(1);
    send_pair(16'h3C00, 16'h3C00, 1'b0);
    wait_valid(lat);
    check_int("latency_len1", lat, 1 + CLR_CYC + 1 + MAC_LAT);
    @(posedge CLK); #1;

    // 7: signed operands, -2*2 + 0.5*2 = -3.0
    push_exp(16'hC200, 1'b0);
    pulse_start(2);
    send_pair(16'hC000, 16'h4000, 1'b0);
    send_pair(16'h3800, 16'h4000, 1'b0);
    wait_valid(lat);
    @(posedge CLK); #1;

`ifdef FP16_DOT_NANCHK_EN
    // 6: Inf operand forces qNaN and raises nan_flag; next clean job clears it
    push_exp(16'h7E00, 1'b1);
    pulse_start(2);
    send_pair(16'h7C00, 16'h3C00, 1'b0);
    send_pair(16'h3C00, 16'h3C00, 1'b0);
    wait_valid(lat);
    @(posedge CLK); #1;
    push_exp(16'h4400, 1'b0);
    pulse_start(1);
    send_pair(16'h4000, 16'h4000, 1'b0);
    wait_valid(lat);
    @(posedge CLK); #1;
`endif

    repeat (3) @(posedge CLK);
    #1;
    check_int("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
